dqs_multilane_pattern_detector: RTL
===================================

// Module: dqs_multilane_pattern_detector
// PURPOSE
//  Programmable DQS preamble/interamble detector for NUM_LANES byte lanes, in the read data manager.
//  Pattern and length are loaded at arm time; no fixed table. Each enabled lane matches independently.
//  Flags success only when all enabled lanes match within a skew window. Flags timeout and skew errors.
//  Supports one-shot and continuous re-search modes.
// PARAMETERS
//  NUM_LANES    2   number of DQS lanes
//  MAX_PAT_LEN  16  max pattern length in bits (>=2)
//  TMO_W        8   timeout counter width
// PORTS
//  clk_i        in   1            single clock
//  reset_i      in   1            synchronous, active-high reset
//  en_i         in   1            0 = synchronous clear to IDLE; all pulses low
//  arm_i        in   1            start search; honoured only in IDLE
//  cont_mode_i  in   1            1 = after all_det_o, re-fill and search again without re-arm
//  pat_i        in   MAX_PAT_LEN  pattern, LSB-aligned; bit[len-1] is received first
//  pat_len_i    in   LW           pattern length, LW=$clog2(MAX_PAT_LEN+1)
//  lane_mask_i  in   NUM_LANES    1 = lane participates
//  skew_win_i   in   4            max cycles between first and last lane match
//  timeout_i    in   TMO_W        cycles from arm to give up; 0 = no timeout
//  dqs_i        in   NUM_LANES    sampled DQS per lane
//  busy_o       out  1            high outside IDLE
//  lane_det_o   out  NUM_LANES    1-cycle pulse per lane match
//  all_det_o    out  1            1-cycle pulse: all enabled lanes matched within the window
//  skew_err_o   out  1            1-cycle pulse: window exceeded
//  timeout_o    out  1            1-cycle pulse: timeout reached
// BEHAVIOUR
//  - Reset and en_i=0: state IDLE; shift regs, counters and sticky flags 0; all outputs 0.
//  - Arm, in IDLE with arm_i=1 and lane_mask_i!=0: latch pat, len, mask, skew, timeout, mode.
//    Clear shift regs; go to FILL. arm_i with zero mask is ignored.
//  - Length clamp: len<2 is used as 2; len>MAX_PAT_LEN is used as MAX_PAT_LEN.
//  - Shift: every cycle in FILL/SEARCH, sr <= {sr[MAX-2:0], dqs_i[l]}.
//  - Match: ((sr ^ pat) & ((1<<len)-1)) == 0.
//  - FILL: counts len samples, then goes to SEARCH. Matches are suppressed until then.
//  - SEARCH: the final pattern bit is sampled at edge k; lane_det_o[l] is high after edge k+1.
//    Each lane sets a sticky flag and pulses once only per search.
//  - Skew counter starts at 0 on the edge the first lane flag sets and increments each cycle.
//    All masked flags set with cnt<=skew_win: all_det_o pulses the next cycle, state goes to DONE.
//    cnt>skew_win with flags incomplete: skew_err_o pulses, state goes to DONE.
//  - Timeout counter starts at arm. When it reaches timeout_i (!=0) while not in DONE:
//    timeout_o pulses, state goes to DONE.
//  - Same-cycle priority: all_det > skew_err > timeout. Only one status pulse is raised per search.
//  - DONE lasts 1 cycle. Next state is FILL if cont_mode=1 and the result was all_det
//    (flags, skew and timeout cleared). Otherwise IDLE.
//  - arm_i outside IDLE is ignored. Latched settings do not follow input changes mid-search.
//  - Reset or en_i=0 mid-search aborts silently: no pulse is emitted.
//  - Counters saturate; they never wrap.
// STRUCTURE
//  - Package dqs_pd_pkg: state enum {IDLE,FILL,SEARCH,DONE}; function clamp_len().
//  - Sub-module dqs_lane_matcher: per-lane shift reg, masked compare, sticky flag, det pulse.
//    Instantiated NUM_LANES times via generate.
//  - Top holds the FSM, fill, skew and timeout counters, and output registers.
// TESTING
//  1. pat=4'b0010, len=4, mask=2'b11; both lanes get 0,0,1,0 right after FILL
//     -> lane_det_o=2'b11 once; all_det_o next cycle; busy_o drops 2 cycles later.
//  2. Same pattern, lane1 delayed 3 cycles, skew_win=2 -> skew_err_o pulses, no all_det_o.
//     Rerun with skew_win=3 -> all_det_o pulses.
//  3. timeout_i=10, dqs held 1 -> timeout_o pulses 10 cycles after arm; lane_det_o stays 0.
//  4. pat=0, len=4, dqs held 0 from arm -> lane_det_o only after 4 FILL samples, never earlier.
//     len=1 behaves as len=2.
//  5. mask=2'b01, lane1 toggling garbage, lane0 gets the pattern -> all_det_o pulses; lane_det_o[1]=0.
//  6. reset_i high after 3 of 4 pattern bits -> no pulses. Re-arm with cont_mode=1, send pattern twice
//     -> two all_det_o pulses, no re-arm.

Source files
------------

// File: rtl/dqs_pd_pkg.sv
// Shared types and helpers for the DQS multi-lane pattern detector.
//   state_e    : controller states
//   clamp_len(): maps a requested pattern length onto the legal range [2, max_len]
package dqs_pd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Wide enough that the skew counter can pass the largest 4-bit window.
    localparam int unsigned SKEW_CNT_W = 5;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len < 2) begin
            return 2;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/dqs_multilane_pattern_detector_lane.sv
// Per-lane matcher: shift register of sampled DQS bits, compare of the
// youngest len_i bits against the pattern, sticky match flag and a one-cycle
// detect pulse.
//   clk_i     : clock
//   clr_i     : synchronous clear (reset or disable)
//   load_i    : start of a new fill; clears shift register and flag
//   shift_i   : shift dqs_i in this cycle
//   search_i  : compare enabled this cycle
//   lane_en_i : lane participates in the current search
//   pat_i     : latched pattern, LSB-aligned
//   len_i     : latched, already clamped pattern length
//   dqs_i     : sampled DQS bit for this lane
//   flag_o    : sticky "this lane has matched" flag
//   det_o     : one-cycle detect pulse
module dqs_lane_matcher
    import dqs_pd_pkg::*;
#(
    parameter int unsigned MAX_PAT_LEN = 16,
    parameter int unsigned LW          = 5
) (
    input  logic                   clk_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic                   search_i,
    input  logic                   lane_en_i,
    input  logic [MAX_PAT_LEN-1:0] pat_i,
    input  logic [LW-1:0]          len_i,
    input  logic                   dqs_i,
    output logic                   flag_o,
    output logic                   det_o
);

    logic [MAX_PAT_LEN-1:0] sr_q, sr_d;
    logic [MAX_PAT_LEN-1:0] len_mask;
    logic                   flag_q, flag_d;
    logic                   det_q, det_d;
    logic                   match;

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(MAX_PAT_LEN); i++) begin
            len_mask[i] = (i < int'(len_i));
        end
        match = (((sr_q ^ pat_i) & len_mask) == '0);

        sr_d   = sr_q;
        det_d  = search_i & lane_en_i & match & ~flag_q;
        flag_d = flag_q | det_d;
        if (shift_i) begin
            sr_d = {sr_q[MAX_PAT_LEN-2:0], dqs_i};
        end
        if (load_i) begin
            sr_d   = '0;
            flag_d = 1'b0;
            det_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sr_q   <= '0;
            flag_q <= 1'b0;
            det_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            flag_q <= flag_d;
            det_q  <= det_d;
        end
    end

    assign flag_o = flag_q;
    assign det_o  = det_q;

endmodule

// File: rtl/dqs_multilane_pattern_detector.sv
// Programmable DQS preamble/interamble detector across NUM_LANES byte lanes.
// Settings are latched at arm; each enabled lane matches independently and a
// success pulse is raised only when every enabled lane matched within the
// skew window. Timeout and skew errors end the search with a status pulse.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : 0 clears to IDLE
//   arm_i          : start search (IDLE only, non-zero lane mask)
//   cont_mode_i    : re-fill and search again after a success
//   pat_i/pat_len_i: pattern (bit[len-1] received first) and its length
//   lane_mask_i    : participating lanes
//   skew_win_i     : max cycles between first and last lane match
//   timeout_i      : cycles from arm before giving up, 0 = never
//   dqs_i          : sampled DQS per lane
//   busy_o         : not IDLE
//   lane_det_o     : per-lane match pulse
//   all_det_o, skew_err_o, timeout_o : one-cycle status pulses
//
// state  | meaning
// IDLE   | waiting for arm
// FILL   | collecting the first len samples, matches suppressed
// SEARCH | comparing every cycle, tracking skew and timeout
// DONE   | one cycle after a status pulse; re-fill or return to IDLE
module dqs_multilane_pattern_detector
    import dqs_pd_pkg::*;
#(
    parameter  int unsigned NUM_LANES   = 2,
    parameter  int unsigned MAX_PAT_LEN = 16,
    parameter  int unsigned TMO_W       = 8,
    localparam int unsigned LW          = $clog2(MAX_PAT_LEN + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   arm_i,
    input  logic                   cont_mode_i,
    input  logic [MAX_PAT_LEN-1:0] pat_i,
    input  logic [LW-1:0]          pat_len_i,
    input  logic [NUM_LANES-1:0]   lane_mask_i,
    input  logic [3:0]             skew_win_i,
    input  logic [TMO_W-1:0]       timeout_i,
    input  logic [NUM_LANES-1:0]   dqs_i,
    output logic                   busy_o,
    output logic [NUM_LANES-1:0]   lane_det_o,
    output logic                   all_det_o,
    output logic                   skew_err_o,
    output logic                   timeout_o
);

    state_e                  state_q, state_d;
    logic [MAX_PAT_LEN-1:0]  pat_q, pat_d;
    logic [LW-1:0]           len_q, len_d;
    logic [NUM_LANES-1:0]    mask_q, mask_d;
    logic [3:0]              win_q, win_d;
    logic [TMO_W-1:0]        tmo_lim_q, tmo_lim_d;
    logic                    cont_q, cont_d;
    logic [LW-1:0]           fill_cnt_q, fill_cnt_d;
    logic [SKEW_CNT_W-1:0]   skew_cnt_q, skew_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    all_det_q, all_det_d;
    logic                    skew_err_q, skew_err_d;
    logic                    timeout_q, timeout_d;

    logic                    clr, load, shift, search;
    logic [NUM_LANES-1:0]    lane_flag;
    logic [NUM_LANES-1:0]    masked_flags;
    logic                    any_flag, all_flags;
    logic [TMO_W-1:0]        tmo_nxt;
    logic [SKEW_CNT_W-1:0]   skew_nxt;
    logic                    tmo_hit;
    logic                    in_win;

    assign clr    = reset_i | ~en_i;
    assign shift  = (state_q == FILL) || (state_q == SEARCH);
    assign search = (state_q == SEARCH);

    for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
        dqs_lane_matcher #(
            .MAX_PAT_LEN (MAX_PAT_LEN),
            .LW          (LW)
        ) u_lane (
            .clk_i     (clk_i),
            .clr_i     (clr),
            .load_i    (load),
            .shift_i   (shift),
            .search_i  (search),
            .lane_en_i (mask_q[l]),
            .pat_i     (pat_q),
            .len_i     (len_q),
            .dqs_i     (dqs_i[l]),
            .flag_o    (lane_flag[l]),
            .det_o     (lane_det_o[l])
        );
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        mask_d     = mask_q;
        win_d      = win_q;
        tmo_lim_d  = tmo_lim_q;
        cont_d     = cont_q;
        fill_cnt_d = fill_cnt_q;
        skew_cnt_d = skew_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        all_det_d  = 1'b0;
        skew_err_d = 1'b0;
        timeout_d  = 1'b0;
        load       = 1'b0;

        masked_flags = lane_flag & mask_q;
        any_flag     = |masked_flags;
        all_flags    = (masked_flags == mask_q);
        // Counters hold at all-ones instead of wrapping.
        tmo_nxt      = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        skew_nxt     = (skew_cnt_q == '1) ? skew_cnt_q : skew_cnt_q + SKEW_CNT_W'(1);
        // tmo_cnt_q counts edges since arm; the pulse lands on edge number timeout.
        tmo_hit      = (tmo_lim_q != '0) && (tmo_nxt == tmo_lim_q);
        in_win       = (skew_cnt_q <= {1'b0, win_q});

        case (state_q)
            IDLE: begin
                if (arm_i && (lane_mask_i != '0)) begin
                    pat_d      = pat_i;
                    len_d      = LW'(clamp_len(32'(pat_len_i), MAX_PAT_LEN));
                    mask_d     = lane_mask_i;
                    win_d      = skew_win_i;
                    tmo_lim_d  = timeout_i;
                    cont_d     = cont_mode_i;
                    fill_cnt_d = '0;
                    skew_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    load       = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                tmo_cnt_d  = tmo_nxt;
                fill_cnt_d = fill_cnt_q + LW'(1);
                if (fill_cnt_d >= len_q) begin
                    state_d = SEARCH;
                end
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            SEARCH: begin
                tmo_cnt_d  = tmo_nxt;
                // Held at 0 until the first flag is visible, so it reads 0 on
                // the edge that flag set.
                skew_cnt_d = any_flag ? skew_nxt : '0;
                if (any_flag && all_flags && in_win) begin
                    all_det_d = 1'b1;
                    state_d   = DONE;
                end else if (any_flag && !in_win) begin
                    skew_err_d = 1'b1;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // all_det_q is high exactly during the DONE cycle of a success.
                if (cont_q && all_det_q) begin
                    fill_cnt_d = '0;
                    skew_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    load       = 1'b1;
                    state_d    = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            mask_q     <= '0;
            win_q      <= '0;
            tmo_lim_q  <= '0;
            cont_q     <= 1'b0;
            fill_cnt_q <= '0;
            skew_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            all_det_q  <= 1'b0;
            skew_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
            win_q      <= win_d;
            tmo_lim_q  <= tmo_lim_d;
            cont_q     <= cont_d;
            fill_cnt_q <= fill_cnt_d;
            skew_cnt_q <= skew_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            all_det_q  <= all_det_d;
            skew_err_q <= skew_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign all_det_o  = all_det_q;
    assign skew_err_o = skew_err_q;
    assign timeout_o  = timeout_q;

endmodule
